dwt53_lift_row: RTL and testbench

- Reversible 5/3 lifting stage, 1-D horizontal pass, directly downstream of the raw-image read controller.
- Consumes one even/odd sample pair per cycle (the 16-bit sign-extended, <<4 samples that controller produces) and emits one lowpass/highpass coefficient pair per accepted pair.
- Applies whole-sample symmetric extension at line start and line end internally.
- Feeds the coefficient write-back/MMU stage.

---
 rtl/dwt_pkg.sv | 36 +++
 rtl/lift53_step.sv | 27 ++
 rtl/dwt53_lift_row.sv | 133 +++++++++++++
 tb/tb_dwt53_lift_row.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// Shared types and helpers for the 5/3 row lifting stage.
// Build option: DWT53_SAT_EN selects saturating instead of wrapping output narrowing.
package dwt_pkg;

    localparam int DW_DEF = 16;
    localparam int IW_DEF = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // Narrow a sign-extended value to dw bits; result is returned sign-extended to 64 bits
    function automatic logic signed [63:0] narrow(input logic signed [63:0] v,
                                                  input int unsigned dw);
        logic signed [63:0] res;
`ifdef DWT53_SAT_EN
        logic signed [63:0] lim_hi;
        logic signed [63:0] lim_lo;
        lim_hi = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
        lim_lo = -lim_hi - 64'sd1;
        if (v > lim_hi) begin
            res = lim_hi;
        end else if (v < lim_lo) begin
            res = lim_lo;
        end else begin
            res = v;
        end
`else
        res = (v <<< (32'd64 - dw)) >>> (32'd64 - dw);
`endif
        return res;
    endfunction

endpackage

// File: rtl/lift53_step.sv
// Combinational 5/3 predict + update step at internal width IW.
module lift53_step #(
    parameter int IW = 18
) (
    input  logic signed [IW-1:0] x_even,
    input  logic signed [IW-1:0] x_odd,
    input  logic signed [IW-1:0] x_next,
    input  logic signed [IW-1:0] d_prev,
    output logic signed [IW-1:0] d,
    output logic signed [IW-1:0] s
);

    localparam logic signed [IW-1:0] RND = IW'(3'sd2);

    logic signed [IW-1:0] w_pair_sum;
    logic signed [IW-1:0] w_d;
    logic signed [IW-1:0] w_upd_sum;

    // Arithmetic shifts implement the floor of the lifting equations
    assign w_pair_sum = x_even + x_next;
    assign w_d        = x_odd - (w_pair_sum >>> 1);
    assign w_upd_sum  = d_prev + w_d + RND;

    assign d = w_d;
    assign s = x_even + (w_upd_sum >>> 2);

endmodule

// File: rtl/dwt53_lift_row.sv
// Reversible 5/3 horizontal lifting stage with symmetric line-edge extension.
// Build option: DWT53_SAT_EN saturates low_out/high_out instead of wrapping.
module dwt53_lift_row
    import dwt_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk_mmu,
    input  logic          rst,
    input  logic          rst_syn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sol,
    input  logic          eol,
    input  logic [DW-1:0] even_in,
    input  logic [DW-1:0] odd_in,
    output logic [DW-1:0] low_out,
    output logic [DW-1:0] high_out,
    output logic          out_valid,
    output logic          out_sol,
    output logic          out_eol
);

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_out_sol;
    logic                 r_out_eol;
    logic [DW-1:0]        r_low;
    logic [DW-1:0]        r_high;
    logic signed [IW-1:0] r_even;
    logic signed [IW-1:0] r_odd;
    logic signed [IW-1:0] r_dprev;
    logic                 r_first;

    logic                 w_accept;
    logic signed [IW-1:0] w_even_ext;
    logic signed [IW-1:0] w_odd_ext;
    logic signed [IW-1:0] w_x_next;
    logic signed [IW-1:0] w_d_prev;
    logic signed [IW-1:0] w_d;
    logic signed [IW-1:0] w_s;
    logic [DW-1:0]        w_low_n;
    logic [DW-1:0]        w_high_n;

    assign w_accept   = in_valid & r_in_ready;
    assign w_even_ext = {{(IW-DW){even_in[DW-1]}}, even_in};
    assign w_odd_ext  = {{(IW-DW){odd_in[DW-1]}}, odd_in};
    // FLUSH mirrors x[2N] := x[2N-2]; first pair of a line mirrors d[-1] := d[0]
    assign w_x_next   = (r_state == ST_FLUSH) ? r_even : w_even_ext;
    assign w_d_prev   = r_first ? w_d : r_dprev;
    assign w_low_n    = DW'(narrow(64'(w_s), DW));
    assign w_high_n   = DW'(narrow(64'(w_d), DW));

    lift53_step #(
        .IW (IW)
    ) u_step (
        .x_even (r_even),
        .x_odd  (r_odd),
        .x_next (w_x_next),
        .d_prev (w_d_prev),
        .d      (w_d),
        .s      (w_s)
    );

    // Line FSM, held pair and registered coefficient outputs
    always_ff @(posedge clk_mmu) begin
        if (!rst || rst_syn) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sol   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_low       <= {DW{1'b0}};
            r_high      <= {DW{1'b0}};
            r_even      <= {IW{1'b0}};
            r_odd       <= {IW{1'b0}};
            r_dprev     <= {IW{1'b0}};
            r_first     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_accept && sol) begin
                        // A new line start discards any partial line held in RUN
                        r_even     <= w_even_ext;
                        r_odd      <= w_odd_ext;
                        r_first    <= 1'b1;
                        r_state    <= eol ? ST_FLUSH : ST_RUN;
                        r_in_ready <= ~eol;
                    end else if (w_accept && (r_state == ST_RUN)) begin
                        r_low       <= w_low_n;
                        r_high      <= w_high_n;
                        r_out_sol   <= r_first;
                        r_out_eol   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_dprev     <= w_d;
                        r_even      <= w_even_ext;
                        r_odd       <= w_odd_ext;
                        r_first     <= 1'b0;
                        r_state     <= eol ? ST_FLUSH : ST_RUN;
                        r_in_ready  <= ~eol;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_FLUSH: begin
                    r_low       <= w_low_n;
                    r_high      <= w_high_n;
                    r_out_sol   <= r_first;
                    r_out_eol   <= 1'b1;
                    r_out_valid <= 1'b1;
                    r_first     <= 1'b0;
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sol   = r_out_sol;
    assign out_eol   = r_out_eol;
    assign low_out   = r_low;
    assign high_out  = r_high;

endmodule

// File: tb/tb_dwt53_lift_row.sv
// Table-driven bench for dwt53_lift_row: one row per clock cycle with expected outputs.
module tb_dwt53_lift_row;

    logic        clk_mmu = 1'b0;
    logic        rst = 1'b0;
    logic        rst_syn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sol = 1'b0;
    logic        eol = 1'b0;
    logic [15:0] even_in = 16'd0;
    logic [15:0] odd_in = 16'd0;
    logic [15:0] low_out;
    logic [15:0] high_out;
    logic        out_valid;
    logic        out_sol;
    logic        out_eol;

    int errors = 0;
    int checks = 0;

`ifdef DWT53_SAT_EN
    localparam int TRUNC_D0 = 32'h0000_8000;
`else
    localparam int TRUNC_D0 = 32'h0000_0001;
`endif

    typedef struct {
        logic        rn, sr, v, s, e;
        logic [15:0] ev, od;
        logic        xv, cd;
        logic [15:0] xl, xh;
        logic        xs, xe, xr;
    } vec_t;

    vec_t tv[$];

    dwt53_lift_row dut (
        .clk_mmu   (clk_mmu),
        .rst       (rst),
        .rst_syn   (rst_syn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sol       (sol),
        .eol       (eol),
        .even_in   (even_in),
        .odd_in    (odd_in),
        .low_out   (low_out),
        .high_out  (high_out),
        .out_valid (out_valid),
        .out_sol   (out_sol),
        .out_eol   (out_eol)
    );

    always #5 clk_mmu = ~clk_mmu;

    task automatic add(input logic rn, input logic sr, input logic v, input logic s,
                       input logic e, input int ev, input int od, input logic xv,
                       input logic cd, input int xl, input int xh, input logic xs,
                       input logic xe, input logic xr);
        vec_t t;
        t.rn = rn; t.sr = sr; t.v = v; t.s = s; t.e = e;
        t.ev = 16'(ev); t.od = 16'(od);
        t.xv = xv; t.cd = cd; t.xl = 16'(xl); t.xh = 16'(xh);
        t.xs = xs; t.xe = xe; t.xr = xr;
        tv.push_back(t);
    endtask

    // Row with no coefficient expected
    task automatic pin(input logic v, input logic s, input logic e, input int ev,
                       input int od, input logic xr);
        add(1'b1, 1'b0, v, s, e, ev, od, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, xr);
    endtask

    // Row expecting a coefficient pair
    task automatic pout(input logic v, input logic s, input logic e, input int ev,
                        input int od, input int xl, input int xh, input logic xs,
                        input logic xe, input logic xr);
        add(1'b1, 1'b0, v, s, e, ev, od, 1'b1, 1'b1, xl, xh, xs, xe, xr);
    endtask

    // Reset row: everything cleared, in_ready high
    task automatic prst(input logic rn, input logic sr);
        add(rn, sr, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic reset_mid(input logic rn, input logic sr);
        pin(1'b1, 1'b1, 1'b0, 100, 100, 1'b1);
        pout(1'b1, 1'b0, 1'b0, 100, 100, 100, 0, 1'b1, 1'b0, 1'b1);
        pout(1'b1, 1'b0, 1'b0, 100, 100, 100, 0, 1'b0, 1'b0, 1'b1);
        prst(rn, sr);
        pin(1'b1, 1'b0, 1'b0, 100, 100, 1'b1);
        pin(1'b1, 1'b0, 1'b0, 100, 100, 1'b1);
        pin(1'b1, 1'b0, 1'b1, 100, 100, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic chk(input int row, input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, got, exp);
        end
    endtask

    initial begin
        // Reset state, including soft clear alone
        prst(1'b0, 1'b0);
        prst(1'b0, 1'b1);
        prst(1'b1, 1'b1);

        // Line 16,32,48,64 back-to-back
        pin(1'b1, 1'b1, 1'b0, 16, 32, 1'b1);
        pout(1'b1, 1'b0, 1'b1, 48, 64, 16, 0, 1'b1, 1'b0, 1'b0);
        pout(1'b0, 1'b0, 1'b0, 0, 0, 52, 16, 1'b0, 1'b1, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

        // Constant line of 8 pairs
        pin(1'b1, 1'b1, 1'b0, 100, 100, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            pout(1'b1, 1'b0, 1'b0, 100, 100, 100, 0, (k == 1), 1'b0, 1'b1);
        end
        pout(1'b1, 1'b0, 1'b1, 100, 100, 100, 0, 1'b0, 1'b0, 1'b0);
        pout(1'b0, 1'b0, 1'b0, 0, 0, 100, 0, 1'b0, 1'b1, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

        // Single-pair line
        pin(1'b1, 1'b1, 1'b1, 10, 20, 1'b0);
        pout(1'b0, 1'b0, 1'b0, 0, 0, 15, 10, 1'b1, 1'b1, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

        // Narrowing: truncation or saturation of d[0]
        pin(1'b1, 1'b1, 1'b0, 32767, -32768, 1'b1);
        pout(1'b1, 1'b0, 1'b1, 32767, 0, 0, TRUNC_D0, 1'b1, 1'b0, 1'b0);
        pout(1'b0, 1'b0, 1'b0, 0, 0, 8192, -32767, 1'b0, 1'b1, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

        // Mixed-sign line exercising floor on negative sums: x = 0,10,0,31,-41,-7
        pin(1'b1, 1'b1, 1'b0, 0, 10, 1'b1);
        pout(1'b1, 1'b0, 1'b0, 0, 31, 5, 10, 1'b1, 1'b0, 1'b1);
        pout(1'b1, 1'b0, 1'b1, -41, -7, 16, 52, 1'b0, 1'b0, 1'b0);
        pout(1'b0, 1'b0, 1'b0, 0, 0, -19, 34, 1'b0, 1'b1, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

        // Pairs without sol are ignored in IDLE
        pin(1'b1, 1'b0, 1'b0, 5, 5, 1'b1);
        pin(1'b1, 1'b0, 1'b1, 5, 5, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

        // Two gap cycles inside a line (invalid inputs carry junk)
        pin(1'b1, 1'b1, 1'b0, 16, 32, 1'b1);
        pin(1'b0, 1'b1, 1'b1, 999, 999, 1'b1);
        pin(1'b0, 1'b1, 1'b1, 999, 999, 1'b1);
        pout(1'b1, 1'b0, 1'b1, 48, 64, 16, 0, 1'b1, 1'b0, 1'b0);
        pout(1'b0, 1'b0, 1'b0, 0, 0, 52, 16, 1'b0, 1'b1, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

        // New sol mid-line discards the held partial line
        pin(1'b1, 1'b1, 1'b0, 1000, 2000, 1'b1);
        pout(1'b1, 1'b0, 1'b0, 3000, 4000, 1000, 0, 1'b1, 1'b0, 1'b1);
        pin(1'b1, 1'b1, 1'b0, 16, 32, 1'b1);
        pout(1'b1, 1'b0, 1'b1, 48, 64, 16, 0, 1'b1, 1'b0, 1'b0);
        pout(1'b0, 1'b0, 1'b0, 0, 0, 52, 16, 1'b0, 1'b1, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

        // Reset mid-line, by rst and by rst_syn
        reset_mid(1'b0, 1'b0);
        reset_mid(1'b1, 1'b1);

        for (int i = 0; i < tv.size(); i++) begin
            rst      = tv[i].rn;
            rst_syn  = tv[i].sr;
            in_valid = tv[i].v;
            sol      = tv[i].s;
            eol      = tv[i].e;
            even_in  = tv[i].ev;
            odd_in   = tv[i].od;
            @(posedge clk_mmu);
            #1;
            chk(i, "out_valid", 16'(out_valid), 16'(tv[i].xv));
            chk(i, "in_ready", 16'(in_ready), 16'(tv[i].xr));
            if (tv[i].cd) begin
                chk(i, "low_out", low_out, tv[i].xl);
                chk(i, "high_out", high_out, tv[i].xh);
                chk(i, "out_sol", 16'(out_sol), 16'(tv[i].xs));
                chk(i, "out_eol", 16'(out_eol), 16'(tv[i].xe));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
